// File: rtl/pwm_mix_scheduler_if.sv
// Bundle between the PWM period logic and the mix scheduler.
// The master drives the strobe, samples, mutes and attenuations; the slave returns the compare value and status.
interface pwm_mix_scheduler_if #(
    parameter int NUM_CHANNELS = 3,
    parameter int DATA_WIDTH   = 9
);
    logic                                 i_cycle_end;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]   i_channels;
    logic [NUM_CHANNELS-1:0]              i_mute;
    logic [NUM_CHANNELS*2-1:0]            i_atten;
    logic [DATA_WIDTH-1:0]                o_compare;
    logic                                 o_compare_valid;
    logic                                 o_busy;
    logic                                 o_clip;
    logic                                 o_overrun;

    modport master (
        output i_cycle_end, i_channels, i_mute, i_atten,
        input  o_compare, o_compare_valid, o_busy, o_clip, o_overrun
    );

    modport slave (
        input  i_cycle_end, i_channels, i_mute, i_atten,
        output o_compare, o_compare_valid, o_busy, o_clip, o_overrun
    );
endinterface

// File: rtl/pwm_mix_scheduler.sv
// Time-multiplexed channel mixer for the PWM output stage.
// A cycle-end strobe snapshots all channel inputs. The channels are then summed one per clock through one
// shared adder, and the saturated result is presented as a new compare value with a one-cycle valid pulse.
module pwm_mix_scheduler #(
    parameter int NUM_CHANNELS = 3,
    parameter int DATA_WIDTH   = 9,
    parameter int OUT_MAX      = 511
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pwm_mix_scheduler_if.slave   bus
);

    // The accumulator can hold NUM_CHANNELS full-scale samples, so the sum never wraps
    localparam int ACC_W = DATA_WIDTH + $clog2(NUM_CHANNELS + 1);
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [ACC_W-1:0] OUT_MAX_ACC = ACC_W'(OUT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_q, ch_d;
    logic [NUM_CHANNELS-1:0]            mute_q, mute_d;
    logic [NUM_CHANNELS*2-1:0]          atten_q, atten_d;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic                  valid_q, valid_d;
    logic                  clip_q, clip_d;
    logic                  overrun_q, overrun_d;

    logic                  busy;
    logic                  start;
    logic                  accum_en;
    logic                  done_en;
    logic                  last;

    logic [DATA_WIDTH-1:0] sel_sample;
    logic                  sel_mute;
    logic [1:0]            sel_atten;
    logic [ACC_W-1:0]      term;

    // Contribution of one channel: zero when muted, otherwise a logical right shift by its attenuation
    function automatic logic [ACC_W-1:0] channel_term(
        input logic [DATA_WIDTH-1:0] sample,
        input logic                  mute,
        input logic [1:0]            shift
    );
        logic [DATA_WIDTH-1:0] shifted;
        shifted = sample >> shift;
        return mute ? '0 : ACC_W'(shifted);
    endfunction

    // Clamp the wide sum to the compare range
    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [ACC_W-1:0] sum);
        return (sum > OUT_MAX_ACC) ? DATA_WIDTH'(OUT_MAX) : sum[DATA_WIDTH-1:0];
    endfunction

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one ACCUM cycle per channel, then a single DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.i_cycle_end) state_d = ST_ACCUM;
            ST_ACCUM: if (last)            state_d = ST_DONE;
            ST_DONE:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // Output/control decode from the current state
    always_comb begin
        busy     = (state_q == ST_ACCUM) || (state_q == ST_DONE);
        start    = (state_q == ST_IDLE) && bus.i_cycle_end;
        accum_en = (state_q == ST_ACCUM);
        done_en  = (state_q == ST_DONE);
        last     = (idx_q == LAST_IDX);
    end

    // Select the snapshot entry for the current channel index
    always_comb begin
        sel_sample = ch_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        sel_mute   = mute_q[idx_q];
        sel_atten  = atten_q[int'(idx_q)*2 +: 2];
        term       = channel_term(sel_sample, sel_mute, sel_atten);
    end

    // Datapath next values: snapshot on start, accumulate in ACCUM, publish in DONE
    always_comb begin
        ch_d      = ch_q;
        mute_d    = mute_q;
        atten_d   = atten_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        compare_d = compare_q;
        valid_d   = 1'b0;
        clip_d    = 1'b0;
        // A strobe that arrives mid-mix, including during DONE, is dropped and flagged
        overrun_d = busy && bus.i_cycle_end;

        if (start) begin
            ch_d    = bus.i_channels;
            mute_d  = bus.i_mute;
            atten_d = bus.i_atten;
            idx_d   = '0;
            acc_d   = '0;
        end

        if (accum_en) begin
            acc_d = acc_q + term;
            idx_d = last ? '0 : idx_q + 1'b1;
        end

        if (done_en) begin
            compare_d = saturate(acc_q);
            valid_d   = 1'b1;
            clip_d    = (acc_q > OUT_MAX_ACC);
        end
    end

    // Control and result registers; reset abandons any mix in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx_q     <= '0;
            acc_q     <= '0;
            compare_q <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            compare_q <= compare_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot registers; always loaded by start before they are read, so no reset is needed
    always_ff @(posedge i_clk) begin
        ch_q    <= ch_d;
        mute_q  <= mute_d;
        atten_q <= atten_d;
    end

    assign bus.o_compare       = compare_q;
    assign bus.o_compare_valid = valid_q;
    assign bus.o_busy          = busy;
    assign bus.o_clip          = clip_q;
    assign bus.o_overrun       = overrun_q;

endmodule

// File: tb/tb_pwm_mix_scheduler.sv
// Directed bench for pwm_mix_scheduler with hand-computed mix results.
module tb_pwm_mix_scheduler;

    localparam int NC = 3;
    localparam int DW = 9;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    pwm_mix_scheduler_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) bus ();

    pwm_mix_scheduler #(
        .NUM_CHANNELS(NC),
        .DATA_WIDTH  (DW),
        .OUT_MAX     (511)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*DW-1:0] pack3(input int a, input int b, input int c);
        logic [DW-1:0] a9, b9, c9;
        a9 = DW'(a);
        b9 = DW'(b);
        c9 = DW'(c);
        return {c9, b9, a9};
    endfunction

    // Pulse the cycle-end strobe for one sampling edge
    task automatic strobe();
        bus.i_cycle_end = 1'b1;
        tick();
        bus.i_cycle_end = 1'b0;
    endtask

    // Run one full mix and check busy, valid timing, compare value and clip
    task automatic run_mix(input logic [NC*DW-1:0] ch, input logic [NC-1:0] mute,
                           input logic [2*NC-1:0] atten, input int exp_cmp, input logic exp_clip);
        bus.i_channels = ch;
        bus.i_mute     = mute;
        bus.i_atten    = atten;
        strobe();
        chk("busy_e0", 32'(bus.o_busy), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("busy_acc", 32'(bus.o_busy), 32'd1);
            chk("valid_early", 32'(bus.o_compare_valid), 32'd0);
        end
        tick();
        chk("valid", 32'(bus.o_compare_valid), 32'd1);
        chk("compare", 32'(bus.o_compare), 32'(exp_cmp));
        chk("clip", 32'(bus.o_clip), 32'(exp_clip));
        chk("busy_after", 32'(bus.o_busy), 32'd0);
        tick();
        chk("valid_drop", 32'(bus.o_compare_valid), 32'd0);
        chk("clip_drop", 32'(bus.o_clip), 32'd0);
        chk("compare_hold", 32'(bus.o_compare), 32'(exp_cmp));
    endtask

    initial begin
        int vcount;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.i_cycle_end = 1'b0;
        bus.i_channels  = '0;
        bus.i_mute      = '0;
        bus.i_atten     = '0;
        tick();
        tick();
        chk("rst_compare", 32'(bus.o_compare), 32'd0);
        chk("rst_valid", 32'(bus.o_compare_valid), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_clip", 32'(bus.o_clip), 32'd0);
        chk("rst_overrun", 32'(bus.o_overrun), 32'd0);
        rst = 1'b0;
        tick();

        // Basic mix: 100+50+25
        run_mix(pack3(100, 50, 25), 3'b000, 6'b00_00_00, 175, 1'b0);
        // Saturation: 600 clips, exactly 511 does not
        run_mix(pack3(300, 200, 100), 3'b000, 6'b00_00_00, 511, 1'b1);
        run_mix(pack3(311, 100, 100), 3'b000, 6'b00_00_00, 511, 1'b0);
        // Attenuation {1,2,3} with channel 1 muted: 200+0+50
        run_mix(pack3(400, 400, 400), 3'b010, {2'd3, 2'd2, 2'd1}, 250, 1'b0);
        // Full-scale channels: sum 1533 must not wrap
        run_mix(pack3(511, 511, 511), 3'b000, 6'b00_00_00, 511, 1'b1);
        // All muted
        run_mix(pack3(400, 400, 400), 3'b111, 6'b00_00_00, 0, 1'b0);

        // Snapshot isolation: inputs change right after the strobe
        bus.i_channels = pack3(10, 10, 10);
        bus.i_mute     = '0;
        bus.i_atten    = '0;
        strobe();
        bus.i_channels = pack3(90, 90, 90);
        for (int c = 0; c < 3; c++) tick();
        tick();
        chk("snap_valid", 32'(bus.o_compare_valid), 32'd1);
        chk("snap_compare", 32'(bus.o_compare), 32'd30);
        tick();
        run_mix(pack3(90, 90, 90), 3'b000, 6'b00_00_00, 270, 1'b0);

        // Overrun: second strobe two cycles after the first
        bus.i_channels = pack3(1, 2, 3);
        strobe();
        bus.i_channels = pack3(200, 200, 200);
        tick();
        chk("ovr_quiet", 32'(bus.o_overrun), 32'd0);
        bus.i_cycle_end = 1'b1;
        tick();
        bus.i_cycle_end = 1'b0;
        chk("ovr_pulse", 32'(bus.o_overrun), 32'd1);
        vcount = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) chk("ovr_single", 32'(bus.o_overrun), 32'd0);
            if (bus.o_compare_valid) begin
                vcount++;
                chk("ovr_compare", 32'(bus.o_compare), 32'd6);
            end
        end
        chk("ovr_valid_count", 32'(vcount), 32'd1);

        // Strobe coinciding with DONE
        bus.i_channels = pack3(5, 5, 5);
        strobe();
        tick();
        tick();
        tick();
        bus.i_cycle_end = 1'b1;
        tick();
        bus.i_cycle_end = 1'b0;
        chk("done_valid", 32'(bus.o_compare_valid), 32'd1);
        chk("done_compare", 32'(bus.o_compare), 32'd15);
        chk("done_overrun", 32'(bus.o_overrun), 32'd1);
        chk("done_busy", 32'(bus.o_busy), 32'd0);
        tick();
        chk("done_norestart", 32'(bus.o_busy), 32'd0);
        chk("done_ovr_drop", 32'(bus.o_overrun), 32'd0);

        // Reset during ACCUM abandons the mix
        bus.i_channels = pack3(7, 7, 7);
        strobe();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_compare", 32'(bus.o_compare), 32'd0);
        chk("mrst_busy", 32'(bus.o_busy), 32'd0);
        chk("mrst_valid", 32'(bus.o_compare_valid), 32'd0);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.o_compare_valid) vcount++;
        end
        chk("mrst_no_valid", 32'(vcount), 32'd0);
        run_mix(pack3(100, 50, 25), 3'b000, 6'b00_00_00, 175, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_mix_scheduler.md
Name: pwm_mix_scheduler

Overview:
Time-multiplexed mixer and scheduler for the PWM audio output stage. On each PWM cycle-end strobe it snapshots all channel sample outputs, mute bits and attenuation settings. It then accumulates the channels one per clock through a single shared adder, and presents a saturated compare value with a one-cycle valid strobe. The result drives the pwm block's compare/compare_valid inputs, so compare updates only on PWM period boundaries.

Parameters:
NUM_CHANNELS, 3, number of channel inputs; range 1..8.
DATA_WIDTH, 9, width of each channel sample and of o_compare.
OUT_MAX, 511, saturation ceiling for o_compare; must be <= 2^DATA_WIDTH-1.

Ports:
i_clk  input  1  system clock.
i_reset  input  1  synchronous, active-high reset.
i_cycle_end  input  1  one-cycle strobe from pwm marking end of a PWM period.
i_channels  input  NUM_CHANNELS*DATA_WIDTH  packed channel samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
i_mute  input  NUM_CHANNELS  bit k=1 forces channel k contribution to 0.
i_atten  input  NUM_CHANNELS*2  per-channel right-shift attenuation, 0..3, channel k at [2k +: 2].
o_compare  output  DATA_WIDTH  mixed, saturated compare value; held between updates.
o_compare_valid  output  1  one-cycle pulse when o_compare is updated.
o_busy  output  1  high while a mix is in progress (ACCUM or DONE).
o_clip  output  1  one-cycle pulse, coincident with o_compare_valid, when the sum exceeded OUT_MAX.
o_overrun  output  1  one-cycle pulse when i_cycle_end arrives while busy.

Behaviour:
- Reset (i_reset high at a clock edge): state IDLE, index 0, accumulator 0, o_compare 0, o_compare_valid 0, o_busy 0, o_clip 0, o_overrun 0. Reset mid-mix abandons the mix; o_compare returns to 0 and no valid pulse is produced.
- Accumulator width: DATA_WIDTH + clog2(NUM_CHANNELS+1); the sum must never wrap internally.
- States:
  - IDLE -> ACCUM on i_cycle_end. At that edge, register snapshots of i_channels, i_mute and i_atten; set index 0, accumulator 0. Input changes after the snapshot do not affect the current mix.
  - ACCUM: each cycle, accumulator += (mute[idx] ? 0 : ch[idx] >> atten[idx]) as a logical shift, then idx++. After idx = NUM_CHANNELS-1 has been added, go to DONE.
  - DONE: o_compare <= min(acc, OUT_MAX); o_compare_valid pulses high for 1 cycle; o_clip pulses if acc > OUT_MAX; return to IDLE.
- Latency: i_cycle_end sampled at edge E. Channels are accumulated on edges E+1..E+NUM_CHANNELS. o_compare and o_compare_valid update at edge E+NUM_CHANNELS+1, i.e. 4 cycles after the strobe with default parameters.
- o_busy: high from edge E through the edge at which DONE exits; equivalently, high in ACCUM and DONE.
- i_cycle_end while busy: ignored (no restart, no queueing); o_overrun pulses 1 cycle later.
- i_cycle_end in the same cycle DONE is active: counts as busy, so it is ignored and o_overrun pulses.
- Back-to-back strobes spaced >= NUM_CHANNELS+2 cycles apart are all serviced.
- o_compare_valid and o_clip are never high outside the DONE-exit cycle.
- All-muted channels give o_compare = 0 with a valid pulse. A sum exactly equal to OUT_MAX does not clip.

Test Plan:
- Reset, then channels {100,50,25}, mute 0, atten 0; pulse i_cycle_end once -> exactly 4 cycles later o_compare=175, o_compare_valid high 1 cycle, o_clip 0, o_busy high for 4 cycles.
- Channels {300,200,100}, atten 0 -> o_compare=511, o_clip=1 coincident with valid. Repeat with {311,100,100}: sum 511 -> o_compare=511, o_clip=0.
- Channels {400,400,400}, atten {1,2,3}, mute=3'b010 -> o_compare = 200+0+50 = 250.
- Change i_channels from {10,10,10} to {90,90,90} the cycle after i_cycle_end -> o_compare=30. The next strobe yields 270.
- Second i_cycle_end 2 cycles after the first -> o_overrun pulses once; only one valid pulse, with the first mix's value. A strobe during DONE also yields o_overrun.
- Assert i_reset during ACCUM -> no valid pulse; o_compare=0, o_busy=0 next cycle. The subsequent strobe mixes normally.
